// File: rtl/sprite_draw_scheduler.sv
// Per-frame draw sequencer: grants the single VGA write port to each enabled
// sprite drawer in ascending index order, muxes the granted drawer's pixel
// stream straight through, and force-releases any drawer that holds the grant
// for TIMEOUT cycles.
module sprite_draw_scheduler #(
  parameter int unsigned NUM_SRC = 4,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 draw_start,
  input  logic [NUM_SRC-1:0]   enable_mask,
  input  logic [9*NUM_SRC-1:0] src_x,
  input  logic [8*NUM_SRC-1:0] src_y,
  input  logic [6*NUM_SRC-1:0] src_colour,
  input  logic [NUM_SRC-1:0]   src_write,
  input  logic [NUM_SRC-1:0]   src_done,
  output logic [NUM_SRC-1:0]   src_draw,
  output logic [8:0]           x_draw,
  output logic [7:0]           y_draw,
  output logic [5:0]           colour,
  output logic                 VGA_write,
  output logic                 busy,
  output logic                 draw_done,
  output logic [NUM_SRC-1:0]   timeout_flags
);

  localparam int unsigned IdxW = $clog2(NUM_SRC + 1);

  typedef enum logic [1:0] {StIdle, StScan, StGrant, StDone} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] tflag_q, tflag_d;

  // One-hot decode of the scan pointer; all zero once idx reaches NUM_SRC.
  logic [NUM_SRC-1:0] sel;
  logic               idx_end;

  // Decode idx into a one-hot select, avoiding a too-wide bit index.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel[i] = (idx_q == IdxW'(i));
    end
    idx_end = (idx_q == IdxW'(NUM_SRC));
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    tflag_d = tflag_q;
    unique case (state_q)
      StIdle: begin
        if (draw_start) begin
          mask_d  = enable_mask;
          idx_d   = '0;
          tflag_d = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        if (idx_end) begin
          state_d = StDone;
        end else if (|(mask_q & sel)) begin
          cnt_d   = '0;
          state_d = StGrant;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StGrant: begin
        cnt_d = cnt_q + 16'd1;
        // A done arriving on the timeout cycle wins and leaves no flag.
        if (|(src_done & sel)) begin
          idx_d   = idx_q + IdxW'(1);
          state_d = StScan;
        end else if (cnt_q == TIMEOUT - 16'd1) begin
          tflag_d = tflag_q | sel;
          idx_d   = idx_q + IdxW'(1);
          state_d = StScan;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      tflag_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tflag_q <= tflag_d;
    end
  end

  // Grant decode and zero-latency pixel mux driven from registered state only.
  always_comb begin
    src_draw  = '0;
    x_draw    = '0;
    y_draw    = '0;
    colour    = '0;
    VGA_write = 1'b0;
    if (state_q == StGrant) begin
      src_draw = sel;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sel[i]) begin
          x_draw    = src_x[9*i +: 9];
          y_draw    = src_y[8*i +: 8];
          colour    = src_colour[6*i +: 6];
          VGA_write = src_write[i];
        end
      end
    end
  end

  // Status outputs.
  always_comb begin
    busy          = (state_q != StIdle);
    draw_done     = (state_q == StDone);
    timeout_flags = tflag_q;
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Self-checking bench for sprite_draw_scheduler: a drawer model answers each
// grant, a queue holds the expected grant order, and every cycle the mux,
// grant and busy outputs are checked against the bench's own expectation.
module tb_sprite_draw_scheduler;

  localparam int          N  = 4;
  localparam logic [15:0] TO = 16'd16;

  logic           clock = 1'b0;
  logic           reset;
  logic           draw_start;
  logic [N-1:0]   enable_mask;
  logic [9*N-1:0] src_x;
  logic [8*N-1:0] src_y;
  logic [6*N-1:0] src_colour;
  logic [N-1:0]   src_write;
  logic [N-1:0]   src_done;
  logic [N-1:0]   src_draw;
  logic [8:0]     x_draw;
  logic [7:0]     y_draw;
  logic [5:0]     colour;
  logic           VGA_write;
  logic           busy;
  logic           draw_done;
  logic [N-1:0]   timeout_flags;

  sprite_draw_scheduler #(
    .NUM_SRC(N),
    .TIMEOUT(TO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .draw_start   (draw_start),
    .enable_mask  (enable_mask),
    .src_x        (src_x),
    .src_y        (src_y),
    .src_colour   (src_colour),
    .src_write    (src_write),
    .src_done     (src_done),
    .src_draw     (src_draw),
    .x_draw       (x_draw),
    .y_draw       (y_draw),
    .colour       (colour),
    .VGA_write    (VGA_write),
    .busy         (busy),
    .draw_done    (draw_done),
    .timeout_flags(timeout_flags)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  // Frame results and drawer configuration.
  int   f_cycles;
  int   f_done_cnt;
  int   f_len[N];
  int   done_delay[N];
  logic fix1;

  task automatic run_frame(input logic [N-1:0] m, input int inject_src, input int reset_src,
                           input int budget);
    int           hold[N];
    int           cur;
    int           k;
    int           phase;
    logic [N-1:0] prev;
    logic [N-1:0] exp_sd;
    logic [8:0]   ex;
    logic [7:0]   ey;
    logic [5:0]   ec;
    logic         ew;
    @(negedge clock);
    enable_mask = m;
    draw_start  = 1'b1;
    src_done    = '0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) exp_q.push_back(i);
      hold[i]  = 0;
      f_len[i] = 0;
    end
    cur        = -1;
    prev       = '0;
    k          = 0;
    phase      = 0;
    f_cycles   = 0;
    f_done_cnt = 0;
    while (phase < 3) begin
      @(negedge clock);
      k++;
      draw_start = 1'b0;
      reset      = 1'b0;
      for (int i = 0; i < N; i++) begin
        src_x[9*i +: 9]      = 9'($urandom);
        src_y[8*i +: 8]      = 8'($urandom);
        src_colour[6*i +: 6] = 6'($urandom);
        src_write[i]         = 1'($urandom);
      end
      if (fix1) begin
        src_x[17:9]     = 9'd120;
        src_y[15:8]     = 8'd63;
        src_colour[11:6] = 6'h2A;
        src_write[1]    = 1'b1;
      end
      #1;
      if (phase == 2) begin
        n_tests++;
        if ({src_draw, x_draw, y_draw, colour, VGA_write, busy, draw_done, timeout_flags} !== '0)
          begin
          n_fail++;
          $display("FAIL reset_mid_outputs: got sd=%b x=%0d y=%0d c=%0h w=%b busy=%b dd=%b tf=%b, want all 0",
                   src_draw, x_draw, y_draw, colour, VGA_write, busy, draw_done, timeout_flags);
        end
        src_done = '0;
        exp_q.delete();
        phase = 3;
      end else if (phase == 1) begin
        n_tests++;
        if (busy !== 1'b0 || draw_done !== 1'b0 || src_draw !== '0) begin
          n_fail++;
          $display("FAIL after_done: got busy=%b draw_done=%b src_draw=%b, want 0 0 0",
                   busy, draw_done, src_draw);
        end
        phase = 3;
      end else begin
        if (k == 1) begin
          n_tests++;
          if (timeout_flags !== '0) begin
            n_fail++;
            $display("FAIL flags_cleared: got %b want 0", timeout_flags);
          end
        end
        // Grant order comes from the scoreboard.
        if (prev == '0 && src_draw != '0) begin
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          else cur = -1;
        end
        if (src_draw == '0) cur = -1;
        exp_sd = '0;
        if (cur >= 0) exp_sd[cur] = 1'b1;
        n_tests++;
        if (src_draw !== exp_sd) begin
          n_fail++;
          $display("FAIL grant k=%0d: got src_draw=%b want %b", k, src_draw, exp_sd);
        end
        ex = '0; ey = '0; ec = '0; ew = 1'b0;
        if (cur >= 0) begin
          ex = src_x[9*cur +: 9];
          ey = src_y[8*cur +: 8];
          ec = src_colour[6*cur +: 6];
          ew = src_write[cur];
        end
        n_tests++;
        if (x_draw !== ex || y_draw !== ey || colour !== ec || VGA_write !== ew) begin
          n_fail++;
          $display("FAIL mux k=%0d: got x=%0d y=%0d c=%0h w=%b want x=%0d y=%0d c=%0h w=%b",
                   k, x_draw, y_draw, colour, VGA_write, ex, ey, ec, ew);
        end
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy k=%0d: got %b want 1", k, busy);
        end
        // Drawer model: done after done_delay[i] granted cycles (0 = never).
        for (int i = 0; i < N; i++) begin
          if (src_draw[i]) begin
            hold[i]++;
            f_len[i]++;
          end else begin
            hold[i] = 0;
          end
          src_done[i] = (done_delay[i] > 0) && (hold[i] == done_delay[i]);
        end
        if (inject_src >= 0 && cur == inject_src && hold[cur] == 3) begin
          draw_start  = 1'b1;
          src_done[3] = 1'b1;
          enable_mask = ~m;
        end
        if (draw_done) begin
          f_done_cnt++;
          f_cycles = k;
          phase    = 1;
        end
        if (reset_src >= 0 && cur == reset_src && hold[cur] == 3) begin
          reset = 1'b1;
          phase = 2;
        end
        prev = src_draw;
      end
      if (phase < 3 && k >= budget) begin
        n_tests++;
        n_fail++;
        $display("FAIL frame_budget: got no draw_done after %0d cycles, want draw_done", k);
        phase = 3;
      end
    end
    src_done = '0;
    if (reset_src < 0) begin
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL grants_missing: got %0d ungranted sources, want 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_tests++;
    if ({src_draw, x_draw, y_draw, colour, VGA_write, busy, draw_done, timeout_flags} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got sd=%b x=%0d busy=%b dd=%b tf=%b, want all 0",
               src_draw, x_draw, busy, draw_done, timeout_flags);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_full_order();
    for (int i = 0; i < N; i++) done_delay[i] = 10;
    run_frame(4'b1111, -1, -1, 200);
    n_tests++;
    if (f_done_cnt != 1) begin
      n_fail++;
      $display("FAIL full_done_count: got %0d want 1", f_done_cnt);
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (f_len[i] != 10) begin
        n_fail++;
        $display("FAIL full_len%0d: got %0d want 10", i, f_len[i]);
      end
    end
    n_tests++;
    if (timeout_flags !== '0) begin
      n_fail++;
      $display("FAIL full_flags: got %b want 0000", timeout_flags);
    end
  endtask

  task automatic test_mux();
    fix1 = 1'b1;
    run_frame(4'b1111, -1, -1, 200);
    run_frame(4'b0010, -1, -1, 100);
    n_tests++;
    if (f_len[1] != 10) begin
      n_fail++;
      $display("FAIL mux_len1: got %0d want 10", f_len[1]);
    end
    fix1 = 1'b0;
  endtask

  task automatic test_all_masked();
    run_frame(4'b0000, -1, -1, 50);
    n_tests++;
    if (f_cycles != N + 2) begin
      n_fail++;
      $display("FAIL masked_latency: got %0d want %0d", f_cycles, N + 2);
    end
    for (int i = 0; i < N; i++) begin
      n_tests++;
      if (f_len[i] != 0) begin
        n_fail++;
        $display("FAIL masked_grant%0d: got %0d want 0", i, f_len[i]);
      end
    end
  endtask

  task automatic test_timeout();
    done_delay[2] = 0;
    run_frame(4'b0101, -1, -1, 200);
    done_delay[2] = 10;
    n_tests++;
    if (f_len[2] != 16) begin
      n_fail++;
      $display("FAIL timeout_len: got %0d want 16", f_len[2]);
    end
    n_tests++;
    if (timeout_flags !== 4'b0100) begin
      n_fail++;
      $display("FAIL timeout_flags: got %b want 0100", timeout_flags);
    end
    n_tests++;
    if (f_done_cnt != 1) begin
      n_fail++;
      $display("FAIL timeout_done: got %0d want 1", f_done_cnt);
    end
    // The next frame must clear the sticky flags at draw_start.
    run_frame(4'b0001, -1, -1, 100);
    n_tests++;
    if (timeout_flags !== '0) begin
      n_fail++;
      $display("FAIL timeout_clear: got %b want 0000", timeout_flags);
    end
  endtask

  task automatic test_ignored();
    run_frame(4'b1111, 1, -1, 200);
    n_tests++;
    if (f_done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignored_done_count: got %0d want 1", f_done_cnt);
    end
    n_tests++;
    if (f_len[3] != 10) begin
      n_fail++;
      $display("FAIL ignored_len3: got %0d want 10", f_len[3]);
    end
  endtask

  task automatic test_reset_mid();
    run_frame(4'b1111, -1, 2, 200);
    run_frame(4'b1111, -1, -1, 200);
    n_tests++;
    if (f_len[0] != 10 || f_done_cnt != 1) begin
      n_fail++;
      $display("FAIL restart: got len0=%0d done=%0d want 10 1", f_len[0], f_done_cnt);
    end
  endtask

  initial begin
    reset       = 1'b1;
    draw_start  = 1'b0;
    enable_mask = '0;
    src_x       = '0;
    src_y       = '0;
    src_colour  = '0;
    src_write   = '0;
    src_done    = '0;
    fix1        = 1'b0;
    for (int i = 0; i < N; i++) done_delay[i] = 10;
    test_reset();
    test_full_order();
    test_mux();
    test_all_masked();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
